// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the imem request handshake and
// buffers returned words ahead of decode. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_controller #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic [DATA_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_flush_cnt
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];

   logic                  outstanding;
   logic                  can_issue;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         count_after;
   logic [DATA_WIDTH-1:0] redirect_target;

   assign outstanding     = (state_q == S_WAIT) || (state_q == S_DROP);
   assign can_issue       = (count_q + CW'(outstanding)) < CW'(BUF_DEPTH);
   assign push            = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
   assign pop             = instr_valid && instr_ready && !redirect_valid;
   assign count_after     = count_q + CW'(push) - CW'(pop);
   assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);

   assign imem_addr   = pc_q;
   assign instr_valid = (count_q != '0);
   assign instr_out   = instr_valid ? buf_data_q[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]   : '0;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      imem_req = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_after;

      unique case (state_q)
         S_IDLE: if (can_issue) state_d = S_REQ;
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_gnt) begin
               state_d  = S_WAIT;
               req_pc_d = pc_q;
               pc_d     = pc_q + DATA_WIDTH'(4);
            end
         end
         S_WAIT: if (imem_rvalid) state_d = (count_after < CW'(BUF_DEPTH)) ? S_REQ : S_IDLE;
         S_DROP: if (imem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (redirect_valid) begin
         pc_d     = redirect_target;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         unique case (state_q)
            S_REQ:   state_d = imem_gnt    ? S_DROP : S_IDLE;
            // A response arriving with the redirect is consumed right here, so DROP
            // must not keep waiting for one that will never come.
            S_WAIT,
            S_DROP:  state_d = imem_rvalid ? S_IDLE : S_DROP;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: buffer storage is not reset; count_q qualifies it and the outputs are gated
   // to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= imem_rdata;
         buf_pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_flush_q;
   logic        flush_event;

   // Count redirects that actually throw work away: buffered words or a live response.
   assign flush_event = redirect_valid &&
                        ((count_q != '0) || (state_q == S_WAIT) ||
                         ((state_q == S_REQ) && imem_gnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_q + 32'(pop);
         perf_flush_q <= perf_flush_q + 32'(flush_event);
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic
// checked against a transaction-level model (expected instruction queue, PC, one outstanding).
module tb_fetch_controller;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   fetch_controller #(.DATA_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   int n_vec = 0;
   int n_err = 0;

   // reference model
   entry_t      exp_q[$];
   logic [31:0] grant_log[$];
   logic [31:0] m_pc;
   bit          pend, pend_drop;
   logic [31:0] pend_addr;
   int          pend_delay;
   logic [31:0] m_fetch, m_flush;
   bit          rst_prev, stall_prev;
   logic [31:0] stall_addr;
   int          idle_run;

   // stimulus knobs
   int          gnt_pct, ready_pct, redir_pct, dly_min, dly_max;
   bit          rst_drv, force_redir, force_stray;
   logic [31:0] force_target;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      m_pc       = 32'h0;
      pend       = 1'b0;
      pend_drop  = 1'b0;
      pend_delay = 0;
      m_fetch    = '0;
      m_flush    = '0;
      stall_prev = 1'b0;
      idle_run   = 0;
   endtask

   // One clock: check outputs at negedge, drive inputs, advance the model to the next edge.
   task automatic cycle();
      bit pop_ev, flush_ev;
      @(negedge clk);
      check("instr_valid", instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         check("instr_pc", instr_pc, exp_q[0].pc);
         check("instr_out", instr_out, exp_q[0].data);
      end
      if (imem_req) check("req_space", (exp_q.size() + pend) < DEPTH, 1);
      if (stall_prev) begin
         check("req_held", imem_req, 1);
         check("addr_stable", imem_addr, stall_addr);
      end
      if (rst_prev) begin
         check("rst_req", imem_req, 0);
         check("rst_addr", imem_addr, 32'h0);
         check("rst_valid", instr_valid, 0);
         check("rst_out", instr_out, 32'h0);
         check("rst_pc", instr_pc, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, m_fetch);
      check("perf_flush", perf_flush_cnt, m_flush);
`endif

      rst            = rst_drv;
      imem_gnt       = imem_req && ($urandom_range(99) < gnt_pct);
      instr_ready    = ($urandom_range(99) < ready_pct);
      redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
      redirect_pc    = force_redir ? force_target : $urandom;
      if (force_stray) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
      end else if (pend && pend_delay == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend_addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      force_redir = 1'b0;
      force_stray = 1'b0;

      if (!imem_req && !pend && exp_q.size() < DEPTH && !redirect_valid && !rst)
         idle_run++;
      else
         idle_run = 0;
      if (idle_run > 4) begin
         check("idle_bound", idle_run, 4);
         idle_run = 0;
      end

      rst_prev = rst;
      if (rst) begin
         model_clear();
      end else begin
         flush_ev = redirect_valid && (exp_q.size() != 0 || (pend && !pend_drop) ||
                                       (imem_req && imem_gnt));
         pop_ev   = instr_valid && instr_ready && !redirect_valid;
         if (pop_ev) begin
            void'(exp_q.pop_front());
            m_fetch++;
         end
         if (imem_rvalid && pend) begin
            if (!pend_drop && !redirect_valid) exp_q.push_back('{pend_addr, mem_word(pend_addr)});
            pend = 1'b0;
         end else if (pend) begin
            pend_delay--;
         end
         if (imem_req && imem_gnt) begin
            check("grant_addr", imem_addr, m_pc);
            grant_log.push_back(imem_addr);
            m_pc       = m_pc + 32'd4;
            pend       = 1'b1;
            pend_drop  = 1'b0;
            pend_addr  = imem_addr;
            pend_delay = $urandom_range(dly_max, dly_min) - 1;
         end
         if (redirect_valid) begin
            exp_q.delete();
            if (pend) pend_drop = 1'b1;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (flush_ev) m_flush++;
         end
         stall_prev = imem_req && !imem_gnt && !redirect_valid;
         stall_addr = imem_addr;
      end
   endtask

   task automatic set_knobs(input int g, input int r, input int rd, input int dmin, input int dmax);
      gnt_pct = g; ready_pct = r; redir_pct = rd; dly_min = dmin; dly_max = dmax;
   endtask

   task automatic do_reset();
      rst_drv = 1'b1;
      cycle();
      cycle();
      rst_drv = 1'b0;
      grant_log.delete();
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      rst_drv = 1'b0; force_redir = 1'b0; force_stray = 1'b0; force_target = '0;
      rst_prev = 1'b0;
      model_clear();
      set_knobs(100, 100, 0, 1, 1);

      // 1: streaming with immediate grant and 1-cycle response
      do_reset();
      repeat (12) cycle();
      check("t1_grants", grant_log.size() >= 4, 1);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) check("t1_addr", grant_log[i], 32'(4 * i));

      // 2: decode stalled fills the buffer, then resumes at 0x8
      set_knobs(100, 0, 0, 1, 1);
      do_reset();
      repeat (10) cycle();
      check("t2_req_idle", imem_req, 0);
      check("t2_head_pc", instr_pc, 32'h0);
      check("t2_head_data", instr_out, mem_word(32'h0));
      grant_log.delete();
      ready_pct = 100;
      repeat (8) cycle();
      check("t2_resume", (grant_log.size() > 0) ? grant_log[0] : 32'hDEAD_BEEF, 32'h8);

      // 3: grant withheld for 5 cycles
      set_knobs(0, 100, 0, 1, 1);
      do_reset();
      cycle();
      repeat (5) begin
         cycle();
         check("t3_req", imem_req, 1);
         check("t3_addr", imem_addr, 32'h0);
      end

      // 4: redirect to 0x103 while waiting for a response
      set_knobs(100, 100, 0, 3, 3);
      do_reset();
      cycle();
      cycle();
      force_redir = 1'b1; force_target = 32'h103;
      for (int i = 0; i < 20 && grant_log.size() < 2; i++) cycle();
      check("t4_target", (grant_log.size() >= 2) ? grant_log[1] : 32'hDEAD_BEEF, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      check("t4_flush_cnt", m_flush, 1);
`endif

      // 5a: redirect in REQ without grant
      set_knobs(0, 100, 0, 2, 2);
      do_reset();
      cycle();
      cycle();
      force_redir = 1'b1; force_target = 32'h200;
      cycle();
      cycle();
      check("t5a_req_gap", imem_req, 0);
      cycle();
      check("t5a_req", imem_req, 1);
      check("t5a_addr", imem_addr, 32'h200);
      // 5b: redirect coincident with grant goes through DROP
      gnt_pct = 100;
      force_redir = 1'b1; force_target = 32'h300;
      for (int i = 0; i < 20 && grant_log.size() < 2; i++) cycle();
      check("t5b_target", (grant_log.size() >= 2) ? grant_log[1] : 32'hDEAD_BEEF, 32'h300);

      // 6: reset while waiting with one word buffered, then a stray response
      set_knobs(100, 0, 0, 2, 2);
      do_reset();
      for (int i = 0; i < 20 && !(exp_q.size() == 1 && pend); i++) cycle();
      check("t6_setup", exp_q.size() == 1 && pend, 1);
      rst_drv = 1'b1;
      cycle();
      rst_drv = 1'b0;
      grant_log.delete();
      force_stray = 1'b1;
      cycle();
      ready_pct = 100;
      repeat (10) cycle();
      check("t6_restart", (grant_log.size() > 0) ? grant_log[0] : 32'hDEAD_BEEF, 32'h0);

      // randomized traffic
      for (int seg = 0; seg < 6; seg++) begin
         set_knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(10, 0),
                   1, $urandom_range(4, 1));
         if (seg % 2 == 0) do_reset();
         repeat (600) cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
